id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_pkg.sv | 46 ++++
 rtl/id_ex_stage_forward_unit.sv | 31 +++
 rtl/id_ex_stage.sv | 123 ++++++++++++
 tb/tb_id_ex_stage.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX pipeline stage: ALU opcodes, control word
// layout, the bubble control word and the forwarding select encoding.
package id_ex_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLL1 = 4'b0100;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic [3:0] alu_control;
   } ctrl_t;

   // A bubble must never write state, so every enable is cleared; ADD keeps the ALU benign.
   localparam ctrl_t BUBBLE_CTRL = '{
      reg_write:   1'b0,
      mem_read:    1'b0,
      mem_write:   1'b0,
      mem_to_reg:  1'b0,
      alu_src:     1'b0,
      alu_control: ALU_ADD
   };

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                           input logic [31:0] reg_v,
                                           input logic [31:0] wb_v,
                                           input logic [31:0] mem_v);
      case (sel)
         FWD_MEM: fwd_mux = mem_v;
         FWD_WB:  fwd_mux = wb_v;
         default: fwd_mux = reg_v;
      endcase
   endfunction

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Operand forwarding selects for the EX stage: MEM beats WB beats the
// registered value, and x0 is never forwarded.
module forward_unit
   import id_ex_pkg::*;
(
   input  logic [4:0] ex_rs1,
   input  logic [4:0] ex_rs2,
   input  logic [4:0] mem_rd,
   input  logic       mem_reg_write,
   input  logic [4:0] wb_rd,
   input  logic       wb_reg_write,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b
);

   logic mem_live;
   logic wb_live;

   assign mem_live = mem_reg_write && (mem_rd != 5'd0);
   assign wb_live  = wb_reg_write && (wb_rd != 5'd0);

   always_comb begin
      fwd_a = FWD_REG;
      fwd_b = FWD_REG;
      if (mem_live && (mem_rd == ex_rs1))     fwd_a = FWD_MEM;
      else if (wb_live && (wb_rd == ex_rs1))  fwd_a = FWD_WB;
      if (mem_live && (mem_rd == ex_rs2))     fwd_b = FWD_MEM;
      else if (wb_live && (wb_rd == ex_rs2))  fwd_b = FWD_WB;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, stall, load-use hazard detection and
// EX operand forwarding from the MEM and WB stages.
module id_ex_stage
   import id_ex_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        in_valid,
   input  logic [31:0] id_pc,
   input  logic [31:0] id_rs1_data,
   input  logic [31:0] id_rs2_data,
   input  logic [31:0] id_imm,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [4:0]  id_rd,
   input  logic [3:0]  id_alu_control,
   input  logic        id_alu_src,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        id_mem_write,
   input  logic        id_mem_to_reg,
   input  logic [4:0]  mem_rd,
   input  logic [4:0]  wb_rd,
   input  logic        mem_reg_write,
   input  logic        wb_reg_write,
   input  logic [31:0] mem_result,
   input  logic [31:0] wb_result,
   output logic        ex_valid,
   output logic [31:0] ex_pc,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_control,
   output logic [31:0] ex_store_data,
   output logic [4:0]  ex_rd,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write,
   output logic        ex_mem_to_reg,
   output logic        hazard_stall
);

   ctrl_t       ex_ctrl;
   logic [31:0] ex_rs1_data;
   logic [31:0] ex_rs2_data;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rs1;
   logic [4:0]  ex_rs2;
   logic        load_use;
   logic        wb_hit_rs1;
   logic        wb_hit_rs2;
   logic [1:0]  fwd_a;
   logic [1:0]  fwd_b;
   logic [31:0] rs2_fwd;
   ctrl_t       id_ctrl;

   assign id_ctrl = '{
      reg_write:   id_reg_write,
      mem_read:    id_mem_read,
      mem_write:   id_mem_write,
      mem_to_reg:  id_mem_to_reg,
      alu_src:     id_alu_src,
      alu_control: id_alu_control
   };

   assign load_use = in_valid && ex_valid && ex_ctrl.mem_read && (ex_rd != 5'd0)
                     && ((id_rs1 == ex_rd) || (id_rs2 == ex_rd));
   assign hazard_stall = load_use && !reset;

   // While held, a retiring WB write to a held source would otherwise be lost.
   assign wb_hit_rs1 = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs1);
   assign wb_hit_rs2 = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs2);

   always_ff @(posedge clk) begin
      if (reset || flush || load_use) begin
         ex_valid    <= 1'b0;
         ex_ctrl     <= BUBBLE_CTRL;
         ex_rd       <= 5'd0;
         ex_rs1      <= 5'd0;
         ex_rs2      <= 5'd0;
         ex_pc       <= 32'd0;
         ex_rs1_data <= 32'd0;
         ex_rs2_data <= 32'd0;
         ex_imm      <= 32'd0;
      end else if (stall) begin
         if (wb_hit_rs1) ex_rs1_data <= wb_result;
         if (wb_hit_rs2) ex_rs2_data <= wb_result;
      end else begin
         ex_valid    <= in_valid;
         ex_ctrl     <= id_ctrl;
         ex_rd       <= id_rd;
         ex_rs1      <= id_rs1;
         ex_rs2      <= id_rs2;
         ex_pc       <= id_pc;
         ex_rs1_data <= id_rs1_data;
         ex_rs2_data <= id_rs2_data;
         ex_imm      <= id_imm;
      end
   end

   forward_unit u_forward_unit (
      .ex_rs1        (ex_rs1),
      .ex_rs2        (ex_rs2),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b)
   );

   assign alu_a         = fwd_mux(fwd_a, ex_rs1_data, wb_result, mem_result);
   assign rs2_fwd       = fwd_mux(fwd_b, ex_rs2_data, wb_result, mem_result);
   assign alu_b         = ex_ctrl.alu_src ? ex_imm : rs2_fwd;
   assign ex_store_data = rs2_fwd;
   assign alu_control   = ex_ctrl.alu_control;
   assign ex_reg_write  = ex_ctrl.reg_write;
   assign ex_mem_read   = ex_ctrl.mem_read;
   assign ex_mem_write  = ex_ctrl.mem_write;
   assign ex_mem_to_reg = ex_ctrl.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic compared against a transaction-level model of the stage.
module tb_id_ex_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        in_valid;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [3:0]  id_alu_control;
   logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
   logic [4:0]  mem_rd, wb_rd;
   logic        mem_reg_write, wb_reg_write;
   logic [31:0] mem_result, wb_result;
   logic        ex_valid;
   logic [31:0] ex_pc, alu_a, alu_b, ex_store_data;
   logic [3:0]  alu_control;
   logic [4:0]  ex_rd;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
   logic        hazard_stall;

   int errors = 0;
   int checks = 0;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
      .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_alu_control(id_alu_control), .id_alu_src(id_alu_src),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
      .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write),
      .wb_reg_write(wb_reg_write), .mem_result(mem_result), .wb_result(wb_result),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .alu_a(alu_a), .alu_b(alu_b),
      .alu_control(alu_control), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
      .hazard_stall(hazard_stall)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: the instruction currently held in EX, as a record.
   typedef struct {
      bit          valid;
      logic [31:0] pc, d1, d2, imm;
      logic [4:0]  r1, r2, rd;
      logic [3:0]  alu;
      bit          src, rw, mr, mw, m2r;
   } instr_t;

   instr_t m;

   function automatic bool_t_dummy();
      return 0;
   endfunction

   function automatic bit model_hazard();
      return !reset && in_valid && m.valid && m.mr && (m.rd != 0)
             && (id_rs1 == m.rd || id_rs2 == m.rd);
   endfunction

   function automatic logic [31:0] model_fwd(input logic [4:0] idx, input logic [31:0] held);
      if (idx == 0) return held;
      if (mem_reg_write && mem_rd == idx) return mem_result;
      if (wb_reg_write && wb_rd == idx) return wb_result;
      return held;
   endfunction

   always @(posedge clk) begin
      if (reset || flush || model_hazard()) begin
         m = '{valid: 0, pc: 0, d1: 0, d2: 0, imm: 0, r1: 0, r2: 0, rd: 0,
               alu: 4'b0010, src: 0, rw: 0, mr: 0, mw: 0, m2r: 0};
      end else if (stall) begin
         if (wb_reg_write && wb_rd != 0 && wb_rd == m.r1) m.d1 = wb_result;
         if (wb_reg_write && wb_rd != 0 && wb_rd == m.r2) m.d2 = wb_result;
      end else begin
         m = '{valid: in_valid, pc: id_pc, d1: id_rs1_data, d2: id_rs2_data, imm: id_imm,
               r1: id_rs1, r2: id_rs2, rd: id_rd, alu: id_alu_control, src: id_alu_src,
               rw: id_reg_write, mr: id_mem_read, mw: id_mem_write, m2r: id_mem_to_reg};
      end
   end

   // driver tasks
   task automatic set_instr(input bit v, input logic [31:0] pc, input logic [4:0] r1,
                            input logic [4:0] r2, input logic [4:0] rd,
                            input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] imm, input logic [3:0] alu, input bit src,
                            input bit rw, input bit mr, input bit mw, input bit m2r);
      in_valid = v; id_pc = pc; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
      id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_control = alu;
      id_alu_src = src; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
      id_mem_to_reg = m2r;
   endtask

   task automatic clear_fwd();
      mem_rd = 0; wb_rd = 0; mem_reg_write = 0; wb_reg_write = 0;
      mem_result = 0; wb_result = 0;
   endtask

   task automatic test_reset();
      reset = 1; stall = 0; flush = 0;
      clear_fwd();
      set_instr(1, 32'hDEAD_0000, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h33, 4'b0110,
                1, 1, 1, 1, 1);
      repeat (2) @(negedge clk);
      checks++;
      if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || alu_control !== 4'b0010 ||
          ex_reg_write !== 0 || ex_mem_read !== 0 || ex_mem_write !== 0 ||
          ex_mem_to_reg !== 0) begin
         errors++;
         $display("FAIL reset_ctrl: valid=%0b rd=%0d alu=%b rw=%0b mr=%0b mw=%0b m2r=%0b, need 0 0 0010 0 0 0 0",
                  ex_valid, ex_rd, alu_control, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg);
      end
      checks++;
      if (ex_pc !== 0 || alu_a !== 0 || alu_b !== 0 || ex_store_data !== 0 || hazard_stall !== 0) begin
         errors++;
         $display("FAIL reset_data: pc=%h a=%h b=%h sd=%h hz=%0b, need all 0",
                  ex_pc, alu_a, alu_b, ex_store_data, hazard_stall);
      end
      reset = 0;
      set_instr(0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 0);
   endtask

   task automatic test_plain_load();
      set_instr(1, 32'h100, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h20, 4'b0110, 0, 1, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_control !== 4'b0110 || ex_valid !== 1'b1) begin
         errors++;
         $display("FAIL plain_load: a=%0d b=%0d alu=%b valid=%0b, need 5 7 0110 1",
                  alu_a, alu_b, alu_control, ex_valid);
      end
      checks++;
      if (ex_pc !== 32'h100 || ex_rd !== 5'd3 || ex_reg_write !== 1'b1) begin
         errors++;
         $display("FAIL plain_fields: pc=%h rd=%0d rw=%0b, need 100 3 1", ex_pc, ex_rd, ex_reg_write);
      end
      set_instr(1, 32'h104, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h20, 4'b0010, 1, 1, 0, 1, 0);
      @(negedge clk);
      checks++;
      if (alu_b !== 32'h20 || ex_store_data !== 32'd7 || ex_mem_write !== 1'b1) begin
         errors++;
         $display("FAIL imm_select: b=%h sd=%h mw=%0b, need 20 7 1", alu_b, ex_store_data, ex_mem_write);
      end
   endtask

   task automatic test_double_hazard();
      set_instr(1, 32'h200, 5'd3, 5'd0, 5'd6, 32'h11, 32'h0, 32'h0, 4'b0010, 0, 1, 0, 0, 0);
      @(negedge clk);
      mem_rd = 3; mem_result = 32'hAA; mem_reg_write = 1;
      wb_rd = 3; wb_result = 32'hBB; wb_reg_write = 1;
      #1;
      checks++;
      if (alu_a !== 32'hAA) begin
         errors++;
         $display("FAIL fwd_mem_over_wb: alu_a=%h, need aa", alu_a);
      end
      mem_reg_write = 0;
      #1;
      checks++;
      if (alu_a !== 32'hBB) begin
         errors++;
         $display("FAIL fwd_wb: alu_a=%h, need bb", alu_a);
      end
      clear_fwd();
      set_instr(1, 32'h204, 5'd0, 5'd0, 5'd6, 32'h77, 32'h0, 32'h0, 4'b0010, 0, 1, 0, 0, 0);
      @(negedge clk);
      mem_rd = 0; mem_result = 32'hAA; mem_reg_write = 1;
      wb_rd = 0; wb_result = 32'hBB; wb_reg_write = 1;
      #1;
      checks++;
      if (alu_a !== 32'h77) begin
         errors++;
         $display("FAIL fwd_x0: alu_a=%h, need 77", alu_a);
      end
      clear_fwd();
   endtask

   task automatic test_load_use();
      set_instr(1, 32'h300, 5'd2, 5'd0, 5'd4, 32'h8, 32'h0, 32'h10, 4'b0010, 1, 1, 1, 0, 1);
      @(negedge clk);
      set_instr(1, 32'h304, 5'd4, 5'd1, 5'd5, 32'h9, 32'h1, 32'h0, 4'b0010, 0, 1, 0, 0, 0);
      #1;
      checks++;
      if (hazard_stall !== 1'b1) begin
         errors++;
         $display("FAIL load_use_detect: hazard_stall=%0b, need 1", hazard_stall);
      end
      @(negedge clk);
      checks++;
      if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_rd !== 5'd0 ||
          alu_control !== 4'b0010 || hazard_stall !== 1'b0) begin
         errors++;
         $display("FAIL load_use_bubble: valid=%0b rw=%0b rd=%0d alu=%b hz=%0b, need 0 0 0 0010 0",
                  ex_valid, ex_reg_write, ex_rd, alu_control, hazard_stall);
      end
      mem_rd = 4; mem_result = 32'h1234; mem_reg_write = 1;
      @(negedge clk);
      checks++;
      if (ex_valid !== 1'b1 || alu_a !== 32'h1234 || ex_rd !== 5'd5) begin
         errors++;
         $display("FAIL load_use_fwd: valid=%0b alu_a=%h rd=%0d, need 1 1234 5", ex_valid, alu_a, ex_rd);
      end
      clear_fwd();
   endtask

   task automatic test_stall_wb();
      set_instr(1, 32'h400, 5'd0, 5'd9, 5'd7, 32'h0, 32'h1, 32'h0, 4'b0001, 0, 1, 0, 0, 0);
      @(negedge clk);
      stall = 1;
      set_instr(1, 32'h404, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h0, 4'b0000, 0, 1, 0, 0, 0);
      wb_rd = 9; wb_result = 32'h55; wb_reg_write = 1;
      @(negedge clk);
      wb_reg_write = 0; wb_result = 32'h0;
      #1;
      checks++;
      if (alu_b !== 32'h55 || ex_store_data !== 32'h55 || ex_pc !== 32'h400 || ex_valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_wb_capture: b=%h sd=%h pc=%h valid=%0b, need 55 55 400 1",
                  alu_b, ex_store_data, ex_pc, ex_valid);
      end
      in_valid = 0;
      @(negedge clk);
      checks++;
      if (ex_valid !== 1'b1 || ex_pc !== 32'h400 || alu_control !== 4'b0001 || alu_b !== 32'h55) begin
         errors++;
         $display("FAIL stall_hold_idle: valid=%0b pc=%h alu=%b b=%h, need 1 400 0001 55",
                  ex_valid, ex_pc, alu_control, alu_b);
      end
      stall = 0;
      clear_fwd();
   endtask

   task automatic test_flush();
      set_instr(1, 32'h500, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h0, 4'b0110, 0, 1, 0, 1, 0);
      @(negedge clk);
      flush = 1; stall = 1;
      set_instr(1, 32'h504, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h0, 4'b0110, 0, 1, 0, 1, 0);
      @(negedge clk);
      checks++;
      if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0 || alu_control !== 4'b0010) begin
         errors++;
         $display("FAIL flush_over_stall: valid=%0b rw=%0b mw=%0b alu=%b, need 0 0 0 0010",
                  ex_valid, ex_reg_write, ex_mem_write, alu_control);
      end
      flush = 0; stall = 0;
      set_instr(1, 32'h508, 5'd1, 5'd0, 5'd4, 32'h0, 32'h0, 32'h0, 4'b0010, 1, 1, 1, 0, 1);
      @(negedge clk);
      flush = 1;
      set_instr(1, 32'h50C, 5'd0, 5'd4, 5'd6, 32'h0, 32'h0, 32'h0, 4'b0010, 0, 1, 0, 0, 0);
      #1;
      checks++;
      if (hazard_stall !== 1'b1) begin
         errors++;
         $display("FAIL flush_hazard_flag: hazard_stall=%0b, need 1", hazard_stall);
      end
      @(negedge clk);
      flush = 0;
      checks++;
      if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0) begin
         errors++;
         $display("FAIL flush_hazard_bubble: valid=%0b mr=%0b, need 0 0", ex_valid, ex_mem_read);
      end
   endtask

   task automatic test_reset_mid_stall();
      set_instr(1, 32'h600, 5'd1, 5'd0, 5'd4, 32'h3, 32'h0, 32'h0, 4'b0010, 1, 1, 1, 0, 1);
      @(negedge clk);
      stall = 1;
      set_instr(1, 32'h604, 5'd0, 5'd4, 5'd8, 32'h0, 32'h0, 32'h0, 4'b0010, 0, 1, 0, 0, 0);
      reset = 1;
      #1;
      checks++;
      if (hazard_stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_hazard_mask: hazard_stall=%0b, need 0", hazard_stall);
      end
      @(negedge clk);
      checks++;
      if (ex_valid !== 0 || ex_rd !== 0 || alu_control !== 4'b0010 || ex_mem_read !== 0 ||
          ex_reg_write !== 0 || ex_pc !== 0 || alu_a !== 0 || hazard_stall !== 0) begin
         errors++;
         $display("FAIL reset_mid_stall: valid=%0b rd=%0d alu=%b mr=%0b rw=%0b pc=%h a=%h hz=%0b, need 0 0 0010 0 0 0 0 0",
                  ex_valid, ex_rd, alu_control, ex_mem_read, ex_reg_write, ex_pc, alu_a, hazard_stall);
      end
      reset = 0; stall = 0;
      set_instr(1, 32'h608, 5'd1, 5'd2, 5'd3, 32'h9, 32'hA, 32'h0, 4'b0111, 0, 1, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (ex_valid !== 1'b1 || ex_pc !== 32'h608 || alu_control !== 4'b0111) begin
         errors++;
         $display("FAIL post_reset_load: valid=%0b pc=%h alu=%b, need 1 608 0111", ex_valid, ex_pc, alu_control);
      end
   endtask

   task automatic test_random();
      logic [31:0] ea, eb, es;
      logic [3:0]  ops [6];
      ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010;
      ops[3] = 4'b0110; ops[4] = 4'b0111; ops[5] = 4'b0100;
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 39) == 0);
         flush = ($urandom_range(0, 7) == 0);
         stall = ($urandom_range(0, 3) == 0);
         set_instr($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom, ops[$urandom_range(0, 5)], 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom));
         mem_rd = 5'($urandom_range(0, 7)); mem_reg_write = 1'($urandom); mem_result = $urandom;
         wb_rd = 5'($urandom_range(0, 7));  wb_reg_write = 1'($urandom);  wb_result = $urandom;
         #1;
         checks++;
         if (hazard_stall !== model_hazard()) begin
            errors++;
            $display("FAIL rnd_hazard[%0d]: got %0b need %0b", i, hazard_stall, model_hazard());
         end
         @(negedge clk);
         ea = model_fwd(m.r1, m.d1);
         es = model_fwd(m.r2, m.d2);
         eb = m.src ? m.imm : es;
         checks++;
         if (ex_valid !== m.valid || ex_rd !== m.rd || alu_control !== m.alu ||
             ex_reg_write !== m.rw || ex_mem_read !== m.mr || ex_mem_write !== m.mw ||
             ex_mem_to_reg !== m.m2r) begin
            errors++;
            $display("FAIL rnd_ctrl[%0d]: v=%0b rd=%0d alu=%b rw%0b mr%0b mw%0b m2r%0b need v=%0b rd=%0d alu=%b rw%0b mr%0b mw%0b m2r%0b",
                     i, ex_valid, ex_rd, alu_control, ex_reg_write, ex_mem_read, ex_mem_write,
                     ex_mem_to_reg, m.valid, m.rd, m.alu, m.rw, m.mr, m.mw, m.m2r);
         end
         if (m.valid) begin
            checks++;
            if (ex_pc !== m.pc || alu_a !== ea || alu_b !== eb || ex_store_data !== es) begin
               errors++;
               $display("FAIL rnd_data[%0d]: pc=%h a=%h b=%h sd=%h need pc=%h a=%h b=%h sd=%h",
                        i, ex_pc, alu_a, alu_b, ex_store_data, m.pc, ea, eb, es);
            end
         end
      end
      reset = 0; flush = 0; stall = 0;
      clear_fwd();
   endtask

   initial begin
      test_reset();
      test_plain_load();
      test_double_hazard();
      test_load_use();
      test_stall_wb();
      test_flush();
      test_reset_mid_stall();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
